// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) for the
// 4-digit display path; digits are held registers updated only when done pulses.
module bin2bcd_seq #(
   parameter int unsigned BIN_W = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic [3:0]       digit3,
   output logic [3:0]       digit2,
   output logic [3:0]       digit1,
   output logic [3:0]       digit0
);

   localparam int unsigned      CNT_W   = $clog2(BIN_W + 1);
   localparam logic [BIN_W-1:0] BCD_MAX = BIN_W'(9999);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [BIN_W-1:0] shreg_q, shreg_d;
   logic [15:0]      scratch_q, scratch_d;
   logic [15:0]      adj;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;
   logic [15:0]      digits_q, digits_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;
   logic             accept;
   logic             last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         sat_q     <= 1'b0;
         digits_q  <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         sat_q     <= sat_d;
         digits_q  <= digits_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (cnt_q == CNT_W'(1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: saturate on capture, add-3 correction before each shift, and
   // publish the final shifted scratch straight into the held digit registers.
   always_comb begin
      accept    = (state_q == IDLE) && start;
      last      = (state_q == SHIFT) && (cnt_q == CNT_W'(1));
      shreg_d   = shreg_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      sat_d     = sat_q;
      digits_d  = digits_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      adj       = scratch_q;
      for (int unsigned i = 0; i < 4; i++) begin
         if (scratch_q[i*4 +: 4] >= 4'd5)
            adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
      end
      if (accept) begin
         sat_d     = (bin > BCD_MAX);
         shreg_d   = (bin > BCD_MAX) ? BCD_MAX : bin;
         scratch_d = '0;
         cnt_d     = CNT_W'(BIN_W);
      end else if (state_q == SHIFT) begin
         {scratch_d, shreg_d} = {adj, shreg_q} << 1;
         cnt_d                = cnt_q - CNT_W'(1);
         if (last) begin
            digits_d = scratch_d;
            ovf_d    = sat_q;
            done_d   = 1'b1;
         end
      end
   end

   always_comb begin
      busy   = (state_q == SHIFT);
      done   = done_q;
      ovf    = ovf_q;
      digit3 = digits_q[15:12];
      digit2 = digits_q[11:8];
      digit1 = digits_q[7:4];
      digit0 = digits_q[3:0];
   end

endmodule
